// File: rtl/amem_ctl.sv
`timescale 1ns/1ps
// amem_ctl: owns the A-memory RAM port. After reset it zero-fills the RAM,
//   then shares the RAM between the CPU datapath (priority) and the spy port.
// Latency: CPU accesses pass through in the same cycle, and read data is
//   returned the next cycle. A spy write is acked 1 cycle after its grant,
//   and a spy read is acked 2 cycles after its grant.
// Backpressure: cpu_stall during zero-fill and on a forced spy grant.
//   spy_req is a level that the spy holds until spy_ack.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   cpu_aadr/arp/awp/l    CPU address, read strobe, write strobe, write data
//   cpu_amem, cpu_stall   CPU read data (held between reads), stall
//   spy_req/we/addr/wdata spy request, direction, address, write data
//   spy_ack, spy_rdata    one-cycle completion pulse, read data (held)
//   init_busy             zero-fill in progress
//   mem_addr/re/we/wdata  RAM command port (shared address)
//   mem_q                 RAM read data, valid the cycle after mem_re
module amem_ctl #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_aadr,
  input  logic                  cpu_arp,
  input  logic                  cpu_awp,
  input  logic [DATA_WIDTH-1:0] cpu_l,
  output logic [DATA_WIDTH-1:0] cpu_amem,
  output logic                  cpu_stall,
  input  logic                  spy_req,
  input  logic                  spy_we,
  input  logic [ADDR_WIDTH-1:0] spy_addr,
  input  logic [DATA_WIDTH-1:0] spy_wdata,
  output logic                  spy_ack,
  output logic [DATA_WIDTH-1:0] spy_rdata,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [7:0]            starve_cnt;
  logic                  cpu_rd_d;
  logic [DATA_WIDTH-1:0] amem_hold;
  logic [DATA_WIDTH-1:0] spy_rdata_q;

  logic                  cpu_req;
  logic                  starved;
  logic                  spy_grant;
  logic                  cpu_ok;
  logic                  cpu_rd_go;

  // Arbitration. The spy op itself (write, or read command) happens in the
  // IDLE cycle where the grant is made. This way the CPU only loses the RAM
  // when it is idle, or when it is explicitly stalled by a forced grant.
  always_comb begin
    cpu_req   = cpu_arp | cpu_awp;
    starved   = (starve_cnt >= STARVE_MAX);
    spy_grant = (state == ST_IDLE) && spy_req && (!cpu_req || starved);
    cpu_ok    = ((state == ST_IDLE) && !spy_grant) ||
                (state == ST_RD_WAIT) || (state == ST_ACK);
    cpu_rd_go = cpu_arp && cpu_ok;
  end

  // Next state and RAM command mux.
  always_comb begin
    state_nxt = state;
    mem_addr  = cpu_aadr;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = cpu_l;
    cpu_stall = 1'b0;
    init_busy = 1'b0;
    spy_ack   = 1'b0;

    case (state)
      ST_CLEAR: begin
        mem_addr  = clr_addr;
        mem_we    = 1'b1;
        mem_wdata = '0;
        cpu_stall = 1'b1;
        init_busy = 1'b1;
        if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (spy_grant) begin
          mem_addr  = spy_addr;
          mem_we    = spy_we;
          mem_re    = !spy_we;
          mem_wdata = spy_wdata;
          // A grant while the CPU is strobing can only be the forced one.
          cpu_stall = cpu_req;
          state_nxt = spy_we ? ST_ACK : ST_RD_WAIT;
        end else begin
          mem_re = cpu_arp;
          mem_we = cpu_awp;
        end
      end

      // The spy read data lands this cycle, but the RAM port is free for the CPU.
      ST_RD_WAIT: begin
        mem_re    = cpu_arp;
        mem_we    = cpu_awp;
        state_nxt = ST_ACK;
      end

      ST_ACK: begin
        spy_ack   = 1'b1;
        mem_re    = cpu_arp;
        mem_we    = cpu_awp;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // While reset is held, present the post-reset output values.
    // This stops a half-finished operation from touching the RAM.
    if (reset) begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      spy_ack   = 1'b0;
      cpu_stall = CLEAR_ON_RESET;
      init_busy = CLEAR_ON_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr    <= '0;
      starve_cnt  <= 8'd0;
      cpu_rd_d    <= 1'b0;
      amem_hold   <= '0;
      spy_rdata_q <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end

      // The count only advances in IDLE, because that is the only state
      // where a grant could have been given. Any grant or dropped request
      // restarts the count.
      if (!spy_req || spy_grant) begin
        starve_cnt <= 8'd0;
      end else if ((state == ST_IDLE) && (starve_cnt != 8'hFF)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      cpu_rd_d <= cpu_rd_go;
      if (cpu_rd_d) begin
        amem_hold <= mem_q;
      end

      if (state == ST_RD_WAIT) begin
        spy_rdata_q <= mem_q;
      end
    end
  end

  // The CPU sees live RAM data only in the cycle after its own read.
  // Otherwise it sees its last read value, so spy reads stay invisible to it.
  assign cpu_amem  = reset ? '0 : (cpu_rd_d ? mem_q : amem_hold);
  assign spy_rdata = spy_rdata_q;

endmodule

// File: tb/tb_amem_ctl.sv
`timescale 1ns/1ps
// tb_amem_ctl: drives amem_ctl with a behavioural RAM attached.
// The bench uses directed sequences and a vector table, then random CPU/spy traffic.
// The random traffic is checked against a transaction-level model: a memory array plus spy op phases.
module tb_amem_ctl;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIM   = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_aadr;
  logic          cpu_arp;
  logic          cpu_awp;
  logic [DW-1:0] cpu_l;
  logic [DW-1:0] cpu_amem;
  logic          cpu_stall;
  logic          spy_req;
  logic          spy_we;
  logic [AW-1:0] spy_addr;
  logic [DW-1:0] spy_wdata;
  logic          spy_ack;
  logic [DW-1:0] spy_rdata;
  logic          init_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;
  logic          fill_req;

  always #5 clk = ~clk;

  amem_ctl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_aadr(cpu_aadr), .cpu_arp(cpu_arp), .cpu_awp(cpu_awp), .cpu_l(cpu_l),
    .cpu_amem(cpu_amem), .cpu_stall(cpu_stall),
    .spy_req(spy_req), .spy_we(spy_we), .spy_addr(spy_addr), .spy_wdata(spy_wdata),
    .spy_ack(spy_ack), .spy_rdata(spy_rdata), .init_busy(init_busy),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_q(mem_q)
  );

  // RAM: synchronous write, registered read, read-before-write on collision.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
    end else begin
      if (mem_re) mem_q <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_arp = 1'b0; cpu_awp = 1'b0; cpu_aadr = '0; cpu_l = '0;
    spy_req = 1'b0; spy_we = 1'b0; spy_addr = '0; spy_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_spy_ack"},   spy_ack,   64'd0);
    chk({tag, "_mem_re"},    mem_re,    64'd0);
    chk({tag, "_mem_we"},    mem_we,    64'd0);
    chk({tag, "_cpu_stall"}, cpu_stall, 64'd1);
    chk({tag, "_init_busy"}, init_busy, 64'd1);
    chk({tag, "_cpu_amem"},  cpu_amem,  64'd0);
  endtask

  // This task starts in the first CLEAR cycle, just after an edge.
  // It returns at the negedge of the first IDLE cycle.
  task automatic run_clear(output int busy_n, output int we_n, output int bad_addr,
                           output int bad_stall, output int ack_n);
    busy_n = 0; we_n = 0; bad_addr = 0; bad_stall = 0; ack_n = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (!init_busy) break;
      busy_n++;
      if (mem_we) we_n++;
      if (mem_addr !== AW'(c) || mem_wdata !== '0) bad_addr++;
      if (cpu_stall !== 1'b1) bad_stall++;
      if (spy_ack) ack_n++;
      @(posedge clk); #1;
    end
  endtask

  // Latency is counted inclusively: the request cycle is 1, so the ack cycle number is the latency.
  task automatic spy_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat);
    spy_we = we; spy_addr = a; spy_wdata = d; spy_req = 1'b1; lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (spy_ack) begin lat = k + 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    spy_req = 1'b0;
  endtask

  typedef struct {
    logic          arp, awp;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cl;
    logic          sreq, swe;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sd;
    logic          e_re, e_we, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;
  vec_t tv[8];

  logic [DW-1:0] ref_mem [DEPTH];

  // Starvation watchdog for the whole run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int busy_n, we_n, bad_addr, bad_stall, ack_n, lat, k_ack, extra, bad_hold;
    int stall_idx, stall_n, ack_idx;
    int pct, sp_phase, sp_wait, gap, r;
    logic sp_we_m, prev_stall, c_arp, c_awp, busy, grant, e_stall, perf, drop;
    logic [AW-1:0] sp_addr_m, c_addr;
    logic [DW-1:0] sp_d_m, c_l, exp_amem, exp_srd;

    // Vector table: one IDLE cycle each, with the expected RAM command and stall.
    //         arp   awp   caddr    cl            sreq  swe   saddr    sd            re    we    stall addr     wd
    tv[0] = '{1'b1, 1'b0, 10'h055, 32'h11111111, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 10'h055, 32'h0};
    tv[1] = '{1'b0, 1'b1, 10'h1F0, 32'hCAFEF00D, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 10'h1F0, 32'hCAFEF00D};
    tv[2] = '{1'b1, 1'b1, 10'h200, 32'h0BADC0DE, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b1, 1'b0, 10'h200, 32'h0BADC0DE};
    tv[3] = '{1'b0, 1'b0, 10'h077, 32'h0,        1'b1, 1'b0, 10'h3FF, 32'h0,        1'b1, 1'b0, 1'b0, 10'h3FF, 32'h0};
    tv[4] = '{1'b0, 1'b0, 10'h066, 32'h0,        1'b1, 1'b1, 10'h011, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 10'h011, 32'h5A5A5A5A};
    tv[5] = '{1'b1, 1'b0, 10'h0AA, 32'h0,        1'b1, 1'b1, 10'h022, 32'h77777777, 1'b1, 1'b0, 1'b0, 10'h0AA, 32'h0};
    tv[6] = '{1'b0, 1'b1, 10'h0BB, 32'h12121212, 1'b1, 1'b0, 10'h033, 32'h0,        1'b0, 1'b1, 1'b0, 10'h0BB, 32'h12121212};
    tv[7] = '{1'b0, 1'b0, 10'h0CC, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 1'b0, 10'h000, 32'h0};

    // ---- reset, zero-fill, spy request held through CLEAR ----
    idle_inputs();
    reset = 1'b1; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    tick();
    @(negedge clk);
    check_reset_vals("rst");
    chk("rst_spy_rdata", spy_rdata, 64'd0);
    spy_req = 1'b1; spy_we = 1'b0; spy_addr = 10'h3FF;
    @(posedge clk); #1;
    reset = 1'b0;
    run_clear(busy_n, we_n, bad_addr, bad_stall, ack_n);
    chk("clr_cycles", busy_n, 64'd1024);
    chk("clr_we_count", we_n, 64'd1024);
    chk("clr_addr_seq", bad_addr, 64'd0);
    chk("clr_stall", bad_stall, 64'd0);
    chk("clr_no_ack", ack_n, 64'd0);
    k_ack = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (spy_ack) begin k_ack = k; break; end
      @(posedge clk); #1;
    end
    chk("clr_spy_ack_cycle", k_ack, 64'd2);
    chk("clr_spy_rdata_3ff", spy_rdata, 64'd0);
    @(posedge clk); #1;
    spy_req = 1'b0;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (spy_ack) extra++;
      @(posedge clk); #1;
    end
    chk("clr_spy_once", extra, 64'd0);
    spy_op(1'b0, 10'h000, 32'h0, lat);
    chk("spy_rd0_lat", lat, 64'd3);
    chk("spy_rd0_data", spy_rdata, 64'd0);

    // ---- vector table ----
    for (int i = 0; i < 8; i++) begin
      cpu_arp = tv[i].arp; cpu_awp = tv[i].awp; cpu_aadr = tv[i].caddr; cpu_l = tv[i].cl;
      spy_req = tv[i].sreq; spy_we = tv[i].swe; spy_addr = tv[i].saddr; spy_wdata = tv[i].sd;
      @(negedge clk);
      chk($sformatf("vec%0d_re", i), mem_re, tv[i].e_re);
      chk($sformatf("vec%0d_we", i), mem_we, tv[i].e_we);
      chk($sformatf("vec%0d_stall", i), cpu_stall, tv[i].e_stall);
      if (tv[i].e_re || tv[i].e_we) chk($sformatf("vec%0d_addr", i), mem_addr, tv[i].e_addr);
      if (tv[i].e_we) chk($sformatf("vec%0d_wdata", i), mem_wdata, tv[i].e_wd);
      @(posedge clk); #1;
      idle_inputs();
      repeat (4) tick();
    end

    // ---- CPU write then read, data held ----
    cpu_awp = 1'b1; cpu_aadr = 10'h123; cpu_l = 32'hDEADBEEF;
    tick();
    cpu_awp = 1'b0; cpu_arp = 1'b1;
    tick();
    cpu_arp = 1'b0;
    @(negedge clk);
    chk("cpu_rd_123", cpu_amem, 64'hDEADBEEF);
    bad_hold = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      cpu_aadr = AW'($urandom); cpu_l = $urandom;
      @(negedge clk);
      if (cpu_amem !== 32'hDEADBEEF) bad_hold++;
    end
    chk("cpu_rd_hold", bad_hold, 64'd0);
    @(posedge clk); #1;
    idle_inputs();

    // ---- spy write / read with the CPU idle ----
    spy_op(1'b1, 10'h010, 32'hA5A5A5A5, lat);
    chk("spy_wr_lat", lat, 64'd2);
    spy_op(1'b0, 10'h010, 32'h0, lat);
    chk("spy_rd_lat", lat, 64'd3);
    chk("spy_rd_data", spy_rdata, 64'hA5A5A5A5);
    @(negedge clk);
    chk("spy_rd_cpu_amem", cpu_amem, 64'hDEADBEEF);
    @(posedge clk); #1;

    // ---- starvation: CPU reads every cycle, spy write held ----
    stall_idx = -1; stall_n = 0; ack_idx = -1;
    spy_req = 1'b1; spy_we = 1'b1; spy_addr = 10'h300; spy_wdata = 32'h12345678;
    cpu_arp = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cpu_aadr = AW'($urandom_range(255));
      @(negedge clk);
      drop = 1'b0;
      if (cpu_stall) begin stall_n++; if (stall_idx < 0) stall_idx = k; end
      if (spy_ack) begin ack_idx = k; drop = 1'b1; end
      @(posedge clk); #1;
      if (drop) spy_req = 1'b0;
    end
    chk("starve_stall_idx", stall_idx, 64'd16);
    chk("starve_stall_pulses", stall_n, 64'd1);
    chk("starve_ack_idx", ack_idx, 64'd17);
    idle_inputs();
    cpu_arp = 1'b1; cpu_aadr = 10'h300;
    tick();
    cpu_arp = 1'b0;
    @(negedge clk);
    chk("starve_wr_data", cpu_amem, 64'h12345678);
    @(posedge clk); #1;

    // ---- reset while a spy read sits in RD_WAIT ----
    spy_req = 1'b1; spy_we = 1'b0; spy_addr = 10'h010;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rdw_rst");
    @(posedge clk); #1;
    spy_req = 1'b0;
    @(negedge clk);
    chk("rdw_rst_spy_rdata", spy_rdata, 64'd0);
    chk("rdw_rst_ack", spy_ack, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_clear(busy_n, we_n, bad_addr, bad_stall, ack_n);
    chk("rdw_clr_cycles", busy_n, 64'd1024);
    chk("rdw_clr_addr_seq", bad_addr, 64'd0);
    chk("rdw_clr_no_ack", ack_n, 64'd0);

    // ---- random traffic against the transaction model ----
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_amem = '0; exp_srd = '0;
    sp_phase = 0; sp_wait = 0; gap = 2; prev_stall = 1'b0; pct = 30;
    sp_we_m = 1'b0; sp_addr_m = '0; sp_d_m = '0;
    c_arp = 1'b0; c_awp = 1'b0; c_addr = '0; c_l = '0;
    @(posedge clk); #1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) pct = ((n / 250) % 3 == 0) ? 30 : (((n / 250) % 3 == 1) ? 70 : 100);
      if (!prev_stall) begin
        if ($urandom_range(99) < pct) begin
          r = $urandom_range(2);
          c_arp = (r != 1); c_awp = (r != 0);
        end else begin
          c_arp = 1'b0; c_awp = 1'b0;
        end
        c_addr = AW'($urandom_range(31)); c_l = $urandom;
      end
      if (sp_phase == 0) begin
        if (gap > 0) gap--;
        else begin
          sp_phase = 1; sp_wait = 0;
          sp_we_m = 1'($urandom_range(1)); sp_addr_m = AW'($urandom_range(31)); sp_d_m = $urandom;
        end
      end
      cpu_arp = c_arp; cpu_awp = c_awp; cpu_aadr = c_addr; cpu_l = c_l;
      spy_req = (sp_phase != 0); spy_we = sp_we_m; spy_addr = sp_addr_m; spy_wdata = sp_d_m;
      @(negedge clk);
      busy    = c_arp | c_awp;
      grant   = (sp_phase == 1) && (!busy || sp_wait >= LIM);
      e_stall = grant && busy;
      perf    = busy && !e_stall;
      chk("rnd_stall", cpu_stall, e_stall);
      chk("rnd_ack", spy_ack, sp_phase == 3);
      chk("rnd_cpu_amem", cpu_amem, exp_amem);
      chk("rnd_mem_we", mem_we, (perf && c_awp) || (grant && sp_we_m));
      if (sp_phase == 3 && !sp_we_m) chk("rnd_spy_rdata", spy_rdata, exp_srd);
      @(posedge clk);
      if (perf && c_arp) exp_amem = ref_mem[c_addr];
      if (perf && c_awp) ref_mem[c_addr] = c_l;
      case (sp_phase)
        1: begin
          if (grant) begin
            if (sp_we_m) begin ref_mem[sp_addr_m] = sp_d_m; sp_phase = 3; end
            else begin exp_srd = ref_mem[sp_addr_m]; sp_phase = 2; end
          end else begin
            sp_wait++;
          end
        end
        2: sp_phase = 3;
        3: begin sp_phase = 0; gap = $urandom_range(3); end
        default: ;
      endcase
      prev_stall = e_stall;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
